// File: rtl/m_arbiter_port_pkg.sv
// Types shared between the per-master arbiter port and the central arbiter controller.
package a_definitions;

    localparam int DEF_NO_SLAVES   = 3;
    localparam int DEF_ACK_TIMEOUT = 16;

    typedef enum logic [1:0] {
        WAIT   = 2'b00,
        STOP_S = 2'b01,
        STOP_P = 2'b10,
        CLEAR  = 2'b11
    } ctrl_cmd_t;

    typedef enum logic [1:0] {
        END_COM  = 2'b00,
        NAK      = 2'b01,
        WAIT_ACK = 2'b10,
        COM_     = 2'b11
    } mst_cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ACKW,
        COM,
        STOPW,
        HOLD,
        FIN
    } port_state_t;

    function automatic logic is_stop(input ctrl_cmd_t c);
        return (c == STOP_P) || (c == STOP_S);
    endfunction

endpackage

// File: rtl/m_arbiter_port_ack_timer.sv
// Saturating wait counter for the slave acknowledge window; expire flags the last allowed cycle.
module m_ack_timer #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] CNT_MAX  = TW'(ACK_TIMEOUT);
    localparam logic [TW-1:0] CNT_LAST = TW'(ACK_TIMEOUT - 1);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/m_arbiter_port.sv
// Per-master handshake port: turns core requests into arbiter slave-id requests,
// answers grants with ACK/NAK and relays STOP_P/STOP_S pre-emption back to the core.
module m_arbiter_port
    import a_definitions::*;
#(
    parameter int NO_SLAVES   = DEF_NO_SLAVES,
    parameter int S_ID_WIDTH  = $clog2(NO_SLAVES + 1),
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [S_ID_WIDTH-1:0] req_slave,
    input  logic                  xfer_done,
    input  logic                  core_idle,
    input  logic                  slave_ack,
    input  ctrl_cmd_t             cmd,
    output logic [S_ID_WIDTH-1:0] id,
    output mst_cmd_t              com_state,
    output logic                  done,
    output logic                  grant,
    output logic                  stop,
    output logic                  nak_pulse
);

    port_state_t           state_q, state_d;
    ctrl_cmd_t             cmd_q;
    logic [S_ID_WIDTH-1:0] slv_q, slv_d;
    logic [S_ID_WIDTH-1:0] id_q, id_d;
    mst_cmd_t              com_q, com_d;
    logic                  done_q, done_d;
    logic                  grant_q, grant_d;
    logic                  stop_q, stop_d;
    logic                  nak_q, nak_d;
    logic                  tmr_load, tmr_en, tmr_expire;
    logic                  clr_edge, slave_valid;

    // Only a fresh CLEAR is a grant; a CLEAR level left over from a previous owner is not.
    assign clr_edge    = (cmd == CLEAR) && (cmd_q != CLEAR);
    assign slave_valid = (req_slave != '0) && (int'(req_slave) <= NO_SLAVES);

    m_ack_timer #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_ack_timer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (tmr_load),
        .en_i    (tmr_en),
        .expire_o(tmr_expire)
    );

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        slv_d    = slv_q;
        id_d     = id_q;
        com_d    = com_q;
        done_d   = done_q;
        grant_d  = grant_q;
        stop_d   = stop_q;
        nak_d    = 1'b0;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (slave_valid) begin
                        slv_d   = req_slave;
                        id_d    = req_slave;
                        state_d = REQ;
                    end else begin
                        nak_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (clr_edge) begin
                    tmr_load = 1'b1;
                    state_d  = ACKW;
                end
            end
            ACKW: begin
                // stop is still set when resuming after HOLD; the new grant releases it.
                if (slave_ack) begin
                    com_d   = COM_;
                    grant_d = 1'b1;
                    stop_d  = 1'b0;
                    state_d = COM;
                end else if (tmr_expire) begin
                    com_d   = NAK;
                    nak_d   = 1'b1;
                    id_d    = '0;
                    state_d = FIN;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            COM: begin
                if (xfer_done) begin
                    com_d   = END_COM;
                    grant_d = 1'b0;
                    id_d    = '0;
                    state_d = FIN;
                end else if (cmd == STOP_P) begin
                    stop_d  = 1'b1;
                    state_d = STOPW;
                end else if (cmd == STOP_S) begin
                    stop_d  = 1'b1;
                    grant_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = HOLD;
                end
            end
            STOPW: begin
                if (core_idle || xfer_done) begin
                    grant_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!is_stop(cmd)) begin
                    done_d  = 1'b0;
                    com_d   = WAIT_ACK;
                    state_d = REQ;
                end
            end
            FIN: begin
                com_d   = WAIT_ACK;
                stop_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cmd_q   <= WAIT;
            slv_q   <= '0;
            id_q    <= '0;
            com_q   <= WAIT_ACK;
            done_q  <= 1'b0;
            grant_q <= 1'b0;
            stop_q  <= 1'b0;
            nak_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd;
            slv_q   <= slv_d;
            id_q    <= id_d;
            com_q   <= com_d;
            done_q  <= done_d;
            grant_q <= grant_d;
            stop_q  <= stop_d;
            nak_q   <= nak_d;
        end
    end

    assign id        = id_q;
    assign com_state = com_q;
    assign done      = done_q;
    assign grant     = grant_q;
    assign stop      = stop_q;
    assign nak_pulse = nak_q;

endmodule

// File: tb/tb_m_arbiter_port.sv
// Self-checking bench for m_arbiter_port: directed vector table, hand sequences for
// timeout / stale-CLEAR / async reset, and random stimulus against a behavioural model.
module tb_m_arbiter_port;
    import a_definitions::*;

    localparam int NS  = 3;
    localparam int TMO = 16;
    localparam bit H   = 1'b1;
    localparam bit L   = 1'b0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic [1:0] req_slave = 2'd0;
    logic       xfer_done = 1'b0;
    logic       core_idle = 1'b0;
    logic       slave_ack = 1'b0;
    ctrl_cmd_t  cmd = WAIT;
    logic [1:0] id;
    mst_cmd_t   com_state;
    logic       done, grant, stop, nak_pulse;

    int checks = 0;
    int errors = 0;

    m_arbiter_port #(.NO_SLAVES(NS), .ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_slave(req_slave),
        .xfer_done(xfer_done), .core_idle(core_idle), .slave_ack(slave_ack),
        .cmd(cmd), .id(id), .com_state(com_state), .done(done),
        .grant(grant), .stop(stop), .nak_pulse(nak_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       req;
        logic [1:0] rs;
        logic       xd, ci, ack;
        ctrl_cmd_t  cmd;
        logic [1:0] id;
        mst_cmd_t   com;
        logic       done, grant, stop, nak;
    } vec_t;

    vec_t vt[23];

    function automatic logic [7:0] pk(input logic [1:0] i, input mst_cmd_t c,
                                      input logic d, input logic g, input logic s, input logic n);
        return {i, c, d, g, s, n};
    endfunction

    function automatic logic [7:0] dut_out();
        return pk(id, com_state, done, grant, stop, nak_pulse);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b (id,com,done,grant,stop,nak) at %0t", name, act, exp, $time);
        end
    endtask

    // Applies one cycle of inputs, clocks, and returns 1 time unit after the edge.
    task automatic step(input logic r, input logic [1:0] s, input logic x, input logic c,
                        input logic a, input ctrl_cmd_t k);
        req = r; req_slave = s; xfer_done = x; core_idle = c; slave_ack = a; cmd = k;
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: the phase is inferred from the visible outputs plus an ack-window flag.
    logic [1:0] m_id;
    mst_cmd_t   m_com;
    logic       m_done, m_grant, m_stop, m_nak, m_window;
    int         m_age;
    ctrl_cmd_t  m_prev;

    task automatic model_reset();
        m_id = 2'd0; m_com = WAIT_ACK; m_done = 0; m_grant = 0; m_stop = 0; m_nak = 0;
        m_window = 0; m_age = 0; m_prev = WAIT;
    endtask

    task automatic model_step(input logic r, input logic [1:0] s, input logic x, input logic c,
                              input logic a, input ctrl_cmd_t k);
        bit fresh_clear;
        fresh_clear = (k == CLEAR) && (m_prev != CLEAR);
        m_nak = 0;
        if (m_com == END_COM || m_com == NAK) begin
            m_com = WAIT_ACK; m_stop = 0;
        end else if (m_done) begin
            if (k != STOP_P && k != STOP_S) begin m_done = 0; m_com = WAIT_ACK; end
        end else if (m_grant && m_stop) begin
            if (c || x) begin m_grant = 0; m_done = 1; end
        end else if (m_grant) begin
            if (x) begin m_com = END_COM; m_grant = 0; m_id = 2'd0; end
            else if (k == STOP_P) m_stop = 1;
            else if (k == STOP_S) begin m_stop = 1; m_grant = 0; m_done = 1; end
        end else if (m_window) begin
            if (a) begin m_com = COM_; m_grant = 1; m_stop = 0; m_window = 0; end
            else if (m_age == TMO - 1) begin m_com = NAK; m_nak = 1; m_id = 2'd0; m_window = 0; end
            else m_age++;
        end else if (m_id != 0) begin
            if (fresh_clear) begin m_window = 1; m_age = 0; end
        end else if (r) begin
            if (s == 0 || int'(s) > NS) m_nak = 1;
            else m_id = s;
        end
        m_prev = k;
    endtask

    initial begin
        // Directed table: one row per cycle, expected outputs after that cycle's edge.
        vt[0]  = '{H, 2'd2, L, L, L, WAIT,   2'd2, WAIT_ACK, L, L, L, L};
        vt[1]  = '{L, 2'd0, L, L, L, CLEAR,  2'd2, WAIT_ACK, L, L, L, L};
        vt[2]  = '{L, 2'd0, L, L, L, CLEAR,  2'd2, WAIT_ACK, L, L, L, L};
        vt[3]  = '{L, 2'd0, L, L, L, CLEAR,  2'd2, WAIT_ACK, L, L, L, L};
        vt[4]  = '{L, 2'd0, L, L, H, CLEAR,  2'd2, COM_,     L, H, L, L};
        vt[5]  = '{L, 2'd0, L, L, L, CLEAR,  2'd2, COM_,     L, H, L, L};
        vt[6]  = '{L, 2'd0, L, L, L, STOP_P, 2'd2, COM_,     L, H, H, L};
        vt[7]  = '{L, 2'd0, L, L, L, STOP_P, 2'd2, COM_,     L, H, H, L};
        vt[8]  = '{L, 2'd0, L, L, L, STOP_P, 2'd2, COM_,     L, H, H, L};
        vt[9]  = '{L, 2'd0, L, L, L, STOP_P, 2'd2, COM_,     L, H, H, L};
        vt[10] = '{L, 2'd0, L, H, L, STOP_P, 2'd2, COM_,     H, L, H, L};
        vt[11] = '{L, 2'd0, L, L, L, STOP_P, 2'd2, COM_,     H, L, H, L};
        vt[12] = '{L, 2'd0, L, L, L, WAIT,   2'd2, WAIT_ACK, L, L, H, L};
        vt[13] = '{L, 2'd0, L, L, L, CLEAR,  2'd2, WAIT_ACK, L, L, H, L};
        vt[14] = '{L, 2'd0, L, L, H, CLEAR,  2'd2, COM_,     L, H, L, L};
        vt[15] = '{L, 2'd0, L, L, L, STOP_S, 2'd2, COM_,     H, L, H, L};
        vt[16] = '{L, 2'd0, L, L, L, WAIT,   2'd2, WAIT_ACK, L, L, H, L};
        vt[17] = '{L, 2'd0, L, L, L, CLEAR,  2'd2, WAIT_ACK, L, L, H, L};
        vt[18] = '{L, 2'd0, L, L, H, CLEAR,  2'd2, COM_,     L, H, L, L};
        vt[19] = '{L, 2'd0, H, L, L, STOP_P, 2'd0, END_COM,  L, L, L, L};
        vt[20] = '{L, 2'd0, L, L, L, WAIT,   2'd0, WAIT_ACK, L, L, L, L};
        vt[21] = '{H, 2'd0, L, L, L, WAIT,   2'd0, WAIT_ACK, L, L, L, H};
        vt[22] = '{L, 2'd0, L, L, L, WAIT,   2'd0, WAIT_ACK, L, L, L, L};

        repeat (2) @(posedge clk);
        #1;
        check("reset", dut_out(), pk(2'd0, WAIT_ACK, L, L, L, L));
        rst = 1'b0;

        for (int i = 0; i < 23; i++) begin
            step(vt[i].req, vt[i].rs, vt[i].xd, vt[i].ci, vt[i].ack, vt[i].cmd);
            check($sformatf("vec%0d", i), dut_out(),
                  pk(vt[i].id, vt[i].com, vt[i].done, vt[i].grant, vt[i].stop, vt[i].nak));
        end

        // Ack timeout: NAK appears exactly ACK_TIMEOUT cycles after the CLEAR edge.
        step(H, 2'd1, L, L, L, WAIT);
        check("tmo_req", dut_out(), pk(2'd1, WAIT_ACK, L, L, L, L));
        step(L, 2'd0, L, L, L, CLEAR);
        for (int k = 1; k <= TMO; k++) begin
            step(L, 2'd0, L, L, L, CLEAR);
            if (k < TMO) check($sformatf("tmo_wait%0d", k), dut_out(), pk(2'd1, WAIT_ACK, L, L, L, L));
            else         check("tmo_nak", dut_out(), pk(2'd0, NAK, L, L, L, H));
        end
        step(L, 2'd0, L, L, L, WAIT);
        check("tmo_idle", dut_out(), pk(2'd0, WAIT_ACK, L, L, L, L));

        // Stale CLEAR left over from a finished transfer must not grant the next request.
        step(H, 2'd3, L, L, L, WAIT);
        step(L, 2'd0, L, L, L, CLEAR);
        step(L, 2'd0, L, L, H, CLEAR);
        check("stale_com", dut_out(), pk(2'd3, COM_, L, H, L, L));
        step(L, 2'd0, H, L, L, CLEAR);
        check("stale_end", dut_out(), pk(2'd0, END_COM, L, L, L, L));
        step(L, 2'd0, L, L, L, CLEAR);
        step(H, 2'd1, L, L, L, CLEAR);
        for (int k = 0; k < 3; k++) begin
            step(L, 2'd0, L, L, H, CLEAR);
            check($sformatf("stale_nogrant%0d", k), dut_out(), pk(2'd1, WAIT_ACK, L, L, L, L));
        end
        step(L, 2'd0, L, L, L, WAIT);
        step(L, 2'd0, L, L, L, CLEAR);
        step(L, 2'd0, L, L, H, CLEAR);
        check("stale_regrant", dut_out(), pk(2'd1, COM_, L, H, L, L));

        // Asynchronous reset mid-transfer, observed before any clock edge.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", dut_out(), pk(2'd0, WAIT_ACK, L, L, L, L));
        @(posedge clk);
        #1;
        step(L, 2'd0, L, L, L, WAIT);
        rst = 1'b0;
        model_reset();

        // Random traffic against the behavioural model.
        begin
            int ack_pct;
            logic r, x, c, a;
            logic [1:0] s;
            ctrl_cmd_t k;
            ack_pct = 40;
            for (int n = 0; n < 3000; n++) begin
                if (n % 200 == 0) ack_pct = ($urandom_range(0, 1) == 0) ? 5 : 40;
                r = 1'($urandom_range(0, 1));
                s = 2'($urandom_range(0, 3));
                x = ($urandom_range(0, 9) < 2);
                c = ($urandom_range(0, 3) == 0);
                a = ($urandom_range(0, 99) < ack_pct);
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: k = CLEAR;
                    4, 5:       k = WAIT;
                    6, 7:       k = STOP_P;
                    default:    k = STOP_S;
                endcase
                step(r, s, x, c, a, k);
                model_step(r, s, x, c, a, k);
                check($sformatf("rand%0d", n), dut_out(), pk(m_id, m_com, m_done, m_grant, m_stop, m_nak));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
